// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and the data-memory slave bus.
// Aligns and extends load data, rejects misaligned requests, and bounds each bus access with an ack timeout.
module dmem_lsu #(
    parameter int RD_WAIT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_signext_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {IDLE, BUS, RDWAIT, RESP, ERRHOLD} state_t;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] RDW_LAST = 8'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
    localparam bit         RD_ZERO  = (RD_WAIT == 0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        wbwe_q, wbwe_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  sel_q, sel_d;
    logic        signext_q, signext_d;
    logic        aligned;

    function automatic logic [3:0] sel_mask(input logic [1:0] size);
        case (size)
            2'b00:   sel_mask = 4'b0001;
            2'b01:   sel_mask = 4'b0011;
            default: sel_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   rep_data = {4{wdata[7:0]}};
            2'b01:   rep_data = {2{wdata[15:0]}};
            default: rep_data = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction

    // size 11 shares the word alignment rule
    assign aligned = !((req_size == 2'b01 && req_addr[0]) ||
                       (req_size[1] && req_addr[1:0] != 2'b00));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        wbwe_d       = wbwe_q;
        stb_d        = stb_q;
        cyc_d        = cyc_q;
        sel_d        = sel_q;
        resp_valid_d = 1'b0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        signext_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (req_valid && aligned) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    we_d    = req_we;
                    adr_d   = req_we ? req_addr : {req_addr[31:2], 2'b00};
                    dat_d   = req_we ? rep_data(req_size, req_wdata) : 32'h0;
                    sel_d   = req_we ? sel_mask(req_size) : 4'b1111;
                    wbwe_d  = req_we;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    cnt_d   = 8'h0;
                    state_d = BUS;
                end else if (req_valid) begin
                    misalign_d = 1'b1;
                    state_d    = ERRHOLD;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    cnt_d = 8'h0;
                    if (we_q || RD_ZERO) begin
                        cyc_d        = 1'b0;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                        if (!we_q) rdata_d = load_ext(wb_dat_i, off_q, size_q, uns_q);
                    end else begin
                        state_d = RDWAIT;
                    end
                end else if (cnt_q == TO_LAST) begin
                    stb_d     = 1'b0;
                    cyc_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            RDWAIT: begin
                if (cnt_q == RDW_LAST) begin
                    rdata_d      = load_ext(wb_dat_i, off_q, size_q, uns_q);
                    cyc_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            RESP:    state_d = IDLE;
            ERRHOLD: if (!req_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'h0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            rdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            adr_q        <= 32'h0;
            dat_q        <= 32'h0;
            wbwe_q       <= 1'b0;
            stb_q        <= 1'b0;
            cyc_q        <= 1'b0;
            sel_q        <= 4'h0;
            signext_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            wbwe_q       <= wbwe_d;
            stb_q        <= stb_d;
            cyc_q        <= cyc_d;
            sel_q        <= sel_d;
            signext_q    <= signext_d;
        end
    end

    // stall is masked by reset so every output reads 0 while rst_n is low
    assign busy = rst_n && ((state_q == BUS) || (state_q == RDWAIT) ||
                            (state_q == IDLE && req_valid && aligned));

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = rdata_q;
    assign misalign     = misalign_q;
    assign bus_err      = bus_err_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_we_o      = wbwe_q;
    assign wb_stb_o     = stb_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_sel_o     = sel_q;
    assign wb_signext_o = signext_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- CPU-side load/store unit that sits directly upstream of the data memory slave.
- Accepts one load or store per request from the MEM pipeline stage and stalls the pipeline while the access is in flight.
- Drives the Wishbone-style slave bus (combinational ack, one-cycle registered read data), then returns aligned, sign- or zero-extended load data.
- Detects misaligned accesses and bus timeouts.

Parameters:
- RD_WAIT, 1, cycles between ack and wb_dat_i being valid (0..3).
- TIMEOUT, 255, max cycles in BUS without ack before bus_err (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage presents an access; held stable while busy=1.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  1=zero-extend load (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- busy  out  1  pipeline stall.
- resp_valid  out  1  one-cycle pulse, access complete.
- resp_rdata  out  32  extended load data, valid with resp_valid and held until the next load completes.
- misalign  out  1  one-cycle pulse, misaligned request rejected.
- bus_err  out  1  one-cycle pulse, ack timeout.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  bus write data.
- wb_we_o  out  1  bus write enable.
- wb_stb_o  out  1  bus strobe.
- wb_cyc_o  out  1  bus cycle.
- wb_sel_o  out  4  unshifted size mask; the slave shifts it by adr[1:0].
- wb_signext_o  out  1  slave extension control: 1=zero-extend; always driven 1 by this block.
- wb_dat_i  in  32  bus read data.
- wb_ack_i  in  1  bus acknowledge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every output and internal register clears to 0.
  - wb_stb_o and wb_cyc_o drop immediately, even mid-transfer; the in-flight access is abandoned with no resp_valid.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, BUS, RDWAIT, RESP, ERRHOLD.
- IDLE:
  - req_valid & aligned: latch addr/we/size/unsigned/wdata, go to BUS.
  - req_valid & misaligned: pulse misalign next cycle, go to ERRHOLD.
- ERRHOLD: no bus activity, busy=0; return to IDLE when req_valid=0.
- BUS:
  - wb_cyc_o=wb_stb_o=1 with latched fields; timeout counter increments each cycle.
  - ack & store: go to RESP.
  - ack & load & RD_WAIT=0: sample wb_dat_i, go to RESP.
  - ack & load & RD_WAIT>0: go to RDWAIT.
  - counter reaches TIMEOUT with no ack: pulse bus_err, drop stb/cyc, go to IDLE; no resp_valid.
- RDWAIT:
  - stb=0, cyc=1, wb_adr_o held; counts RD_WAIT cycles.
  - Samples wb_dat_i in the last counted cycle, then goes to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE; req_valid is ignored in this state.
- busy = (state is BUS or RDWAIT) | (state==IDLE & req_valid & aligned); combinational.
- Store bus fields:
  - wb_adr_o=addr; wb_we_o=1.
  - wb_sel_o = 0001 (byte), 0011 (half), 1111 (word).
  - wb_dat_o = byte replicated 4x, half replicated 2x, or the word.
- Load bus fields:
  - wb_adr_o = {addr[31:2],2'b00}; wb_sel_o=1111; wb_we_o=0.
  - Lane extraction from addr[1:0] and extension are done inside this block from the raw word.
  - Byte lane k = bits[8k+7:8k]; half at offset 0 = [15:0], offset 2 = [31:16].
  - Sign-extend unless req_unsigned.
- Latency from acceptance edge, zero-wait slave: store resp_valid after 2 cycles; load after 2+RD_WAIT cycles.
- req_size=11 is handled as word, including the alignment check.

Test Plan:
- Store word: addr 0x0000_0010, data 0xDEADBEEF -> one BUS cycle with sel=1111, dat_o=0xDEADBEEF, we=1; resp_valid 2 cycles after accept.
- Store byte: addr 0x13, data 0x000000A5 -> wb_sel_o=0001, wb_dat_o=0xA5A5A5A5, wb_adr_o=0x13.
- Byte loads, slave returns 0x80FF7F01 at word 0x10, RD_WAIT=1:
  - lb at 0x13 -> resp_rdata=0xFFFFFF80.
  - lbu at 0x13 -> 0x00000080.
  - lb at 0x11 -> 0x0000007F.
  - In each case resp_valid 3 cycles after accept and wb_adr_o=0x10.
- Half loads, same data: lh at 0x12 -> 0xFFFF80FF; lhu at 0x10 -> 0x00007F01.
- Misaligned: lw at 0x22 -> misalign pulse, no stb; state stays ERRHOLD until req_valid=0.
- Bus errors:
  - Ack held 0 with TIMEOUT=4 -> bus_err pulse after 4 BUS cycles, stb=0, IDLE.
  - rst_n low during RDWAIT -> all outputs 0 immediately, no resp_valid after release.
